// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS stopwatch counter with run/pause, up/down counting,
// field adjust and lap hold; feeds BCD digits and blink flags to the display.
`timescale 1ns/1ps
module stopwatch_core #(
    parameter int CLK_HZ   = 100000000,
    parameter int TICK_HZ  = 1,
    parameter int ADJ_HZ   = 2,
    parameter int BLINK_HZ = 4,
    parameter int MAX_MIN  = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sel,
    input  logic       adj,
    input  logic       pause_p,
    input  logic       lap_p,
    input  logic       dir,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       lap_held,
    output logic       blink_min,
    output logic       blink_sec,
    output logic       done_p,
    output logic       wrap_p
);
    localparam int DW = $clog2(CLK_HZ + 1);
    localparam int MW = $clog2(MAX_MIN + 1);
    localparam logic [DW-1:0] TICK_TC  = DW'(CLK_HZ / TICK_HZ - 1);
    localparam logic [DW-1:0] ADJ_TC   = DW'(CLK_HZ / ADJ_HZ - 1);
    localparam logic [DW-1:0] BLINK_TC = DW'(CLK_HZ / BLINK_HZ - 1);
    localparam logic [MW-1:0] MIN_TOP  = MW'(MAX_MIN);

    typedef enum logic {ST_PAUSED = 1'b0, ST_RUN = 1'b1} state_t;

    state_t        r_state;
    logic [DW-1:0] r_tick_cnt;
    logic [DW-1:0] r_adj_cnt;
    logic [DW-1:0] r_blink_cnt;
    logic [MW-1:0] r_min;
    logic [5:0]    r_sec;
    logic [MW-1:0] r_lap_min;
    logic [5:0]    r_lap_sec;
    logic          r_lap_held;
    logic          r_blink_on;
    logic          r_adj_d;
    logic          r_done;
    logic          r_wrap;

    logic          w_tick_stb;
    logic          w_adj_stb;
    logic          w_blink_stb;
    logic          w_adj_rise;
    logic [MW-1:0] w_disp_min;
    logic [5:0]    w_disp_sec;
    logic [7:0]    w_min8;
    logic [7:0]    w_sec8;

    assign w_tick_stb  = (r_tick_cnt == TICK_TC);
    assign w_adj_stb   = (r_adj_cnt == ADJ_TC);
    assign w_blink_stb = (r_blink_cnt == BLINK_TC);
    assign w_adj_rise  = adj & ~r_adj_d;

    // Free-running dividers; never resynchronised by pause or adjust.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt  <= '0;
            r_adj_cnt   <= '0;
            r_blink_cnt <= '0;
        end else begin
            r_tick_cnt  <= w_tick_stb  ? '0 : r_tick_cnt  + DW'(1);
            r_adj_cnt   <= w_adj_stb   ? '0 : r_adj_cnt   + DW'(1);
            r_blink_cnt <= w_blink_stb ? '0 : r_blink_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_PAUSED;
            r_min      <= '0;
            r_sec      <= '0;
            r_lap_min  <= '0;
            r_lap_sec  <= '0;
            r_lap_held <= 1'b0;
            r_blink_on <= 1'b0;
            r_adj_d    <= 1'b0;
            r_done     <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            r_adj_d <= adj;

            // Later assignments below (countdown forcing PAUSED) override this toggle.
            if (pause_p) begin
                r_state <= (r_state == ST_RUN) ? ST_PAUSED : ST_RUN;
            end

            if (adj) begin
                if (w_adj_stb) begin
                    if (sel) begin
                        r_sec <= (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
                    end else begin
                        r_min <= (r_min == MIN_TOP) ? '0 : r_min + MW'(1);
                    end
                end
                if (w_blink_stb) begin
                    r_blink_on <= ~r_blink_on;
                end
            end else begin
                r_blink_on <= 1'b0;
                if (w_tick_stb && r_state == ST_RUN) begin
                    if (!dir) begin
                        if (r_sec == 6'd59) begin
                            r_sec <= 6'd0;
                            if (r_min == MIN_TOP) begin
                                r_min  <= '0;
                                r_wrap <= 1'b1;
                            end else begin
                                r_min <= r_min + MW'(1);
                            end
                        end else begin
                            r_sec <= r_sec + 6'd1;
                        end
                    end else if (r_sec == 6'd0 && r_min == '0) begin
                        r_state <= ST_PAUSED;
                    end else if (r_sec == 6'd0) begin
                        r_sec <= 6'd59;
                        r_min <= r_min - MW'(1);
                    end else begin
                        r_sec <= r_sec - 6'd1;
                        if (r_min == '0 && r_sec == 6'd1) begin
                            r_done  <= 1'b1;
                            r_state <= ST_PAUSED;
                        end
                    end
                end
            end

            // Capture uses the pre-update count, so a same-cycle tick is not seen.
            if (w_adj_rise) begin
                r_lap_held <= 1'b0;
            end else if (lap_p) begin
                if (!r_lap_held) begin
                    r_lap_min  <= r_min;
                    r_lap_sec  <= r_sec;
                    r_lap_held <= 1'b1;
                end else begin
                    r_lap_held <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_disp_min = r_lap_held ? r_lap_min : r_min;
        w_disp_sec = r_lap_held ? r_lap_sec : r_sec;
        w_min8     = 8'(w_disp_min);
        w_sec8     = 8'(w_disp_sec);
    end

    assign min_tens  = 4'(w_min8 / 8'd10);
    assign min_ones  = 4'(w_min8 % 8'd10);
    assign sec_tens  = 4'(w_sec8 / 8'd10);
    assign sec_ones  = 4'(w_sec8 % 8'd10);
    assign running   = (r_state == ST_RUN);
    assign lap_held  = r_lap_held;
    assign blink_min = adj & ~sel & r_blink_on;
    assign blink_sec = adj & sel & r_blink_on;
    assign done_p    = r_done;
    assign wrap_p    = r_wrap;

endmodule
